// File: rtl/bcd_to_bin_seq_if.sv
// bcd_to_bin_seq_if: start/operand request and result bundle for the BCD-to-binary converter
interface bcd_to_bin_seq_if #(parameter int NDIG = 2, parameter int OUTW = 7);
  logic              Start;
  logic [4*NDIG-1:0] BCDin;
  logic              Busy;
  logic              Done;
  logic              Err;
  logic [OUTW-1:0]   Bin;
  modport master(output Start, BCDin, input Busy, Done, Err, Bin);
  modport slave(input Start, BCDin, output Busy, Done, Err, Bin);
endinterface

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential reverse double-dabble BCD-to-binary converter, one result bit per clock
module bcd_to_bin_seq #(
  parameter int NDIG = 2,
  parameter int OUTW = 7
) (
  input logic              Clock,
  input logic              Resetn,
  bcd_to_bin_seq_if.slave  bus
);
  localparam int CW = $clog2(OUTW + 1);
  localparam logic [CW-1:0] LAST = CW'(OUTW - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t            state, state_n;
  logic [4*NDIG-1:0] bcd_reg, bcd_shr, bcd_sh;
  logic [OUTW-1:0]   bin_reg, bin_q;
  logic [CW-1:0]     cnt;
  logic              bad, in_bad, err_q, done_q;
  assign bcd_shr  = bcd_reg >> 1;
  assign bus.Busy = state == SHIFT;
  assign bus.Done = done_q;
  assign bus.Err  = err_q;
  assign bus.Bin  = bin_q;
  always_comb begin
    bcd_sh = bcd_shr;
    in_bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      bcd_sh[4*i+:4] = bcd_shr[4*i+:4] >= 4'd8 ? bcd_shr[4*i+:4] - 4'd3 : bcd_shr[4*i+:4];
      in_bad = in_bad | (bus.BCDin[4*i+:4] > 4'd9);
    end
    state_n = state == IDLE  ? (bus.Start ? (in_bad ? DONE : SHIFT) : IDLE) :
              state == SHIFT ? (cnt == LAST ? DONE : SHIFT) : IDLE;
  end
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) state <= IDLE;
    else state <= state_n;
  // Bin/Err publish together with the registered Done as DONE is left
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) begin
      bcd_reg <= '0;
      bin_reg <= '0;
      cnt     <= '0;
      bad     <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      bin_q   <= '0;
    end else begin
      done_q <= state == DONE;
      if (state == IDLE && bus.Start) begin
        bcd_reg <= bus.BCDin;
        bin_reg <= '0;
        cnt     <= '0;
        bad     <= in_bad;
      end else if (state == SHIFT) begin
        bcd_reg <= bcd_sh;
        bin_reg <= {bcd_reg[0], bin_reg[OUTW-1:1]};
        cnt     <= cnt + 1'b1;
      end else if (state == DONE) begin
        bin_q <= bad ? '0 : bin_reg;
        err_q <= bad;
      end
    end
endmodule
